reorder_buffer: RTL and testbench
=================================

# reorder_buffer

SS-wide in-order reorder buffer for the out-of-order core. Accepts up to SS renamed instructions per cycle from rename/dispatch and marks entries complete from CDB broadcasts. Retires up to SS completed instructions per cycle in program order, driving the retired RAT's write port and returning the previous physical mapping of each retiring `rd` to the free list. Flush empties the buffer for mispredict recovery; the front-end RAT is then restored from the retired RAT.

## Interface
- `SS`, 2: superscalar width for dispatch, CDB and retire.
- `ROB_DEPTH`, 16: entry count. Power of two, ≥ 2·SS.
- `PHYS_W`, 6: physical register index width.

Ports (`ROB_W` = log2(`ROB_DEPTH`)):
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous; empties the buffer.
- `dispatch_valid[SS]` in 1: lane allocates an entry. Valid lanes form a prefix starting at lane 0.
- `dispatch_isa_rd[SS]` in 5: architectural destination; 0 means no write.
- `dispatch_phys_rd[SS]` in `PHYS_W`: newly allocated physical destination.
- `dispatch_old_phys_rd[SS]` in `PHYS_W`: prior mapping of `isa_rd`.
- `dispatch_ready` out 1: at least SS free entries.
- `dispatch_rob_idx[SS]` out `ROB_W`: entry index assigned to each lane.
- `cdb_valid[SS]` in 1: completion broadcast.
- `cdb_rob_idx[SS]` in `ROB_W`: completing entry.
- `retire_we` out 1: at least one lane retires this cycle. Drives the retired RAT write enable.
- `retire_valid[SS]` out 1: per-lane retire.
- `retire_isa_rd[SS]` out 5: architectural destination; 0 on non-retiring lanes.
- `retire_phys_rd[SS]` out `PHYS_W`: new mapping to the retired RAT; 0 on non-retiring lanes.
- `free_valid[SS]` out 1: `retire_valid[i]` and `retire_isa_rd[i]` ≠ 0.
- `free_phys_rd[SS]` out `PHYS_W`: old physical register returned to the free list.
- `rob_empty`, `rob_full` out 1: status.

## Operation
- Storage is a circular array of entries {valid, done, isa_rd, phys_rd, old_phys_rd}.
- `head_ptr` and `tail_ptr` are `ROB_W+1` bits; the MSB is the wrap bit.
  - count = tail − head (mod 2^(ROB_W+1)).
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the wrap bits differ.
- Dispatch:
  - Fires when `dispatch_ready` and any `dispatch_valid` is high.
  - Lane i writes entry (tail+i) with valid=1, done=0.
  - Tail advances by the number of valid lanes.
  - `dispatch_valid` while not ready is ignored; the upstream stage holds.
- `dispatch_rob_idx[i]` = low bits of (tail+i), combinational from tail.
- CDB: each valid lane sets done on entry `cdb_rob_idx`. A broadcast to an invalid entry is ignored.
- Retire selection is combinational from registered state only:
  - Lane 0 retires if entry head is valid and done.
  - Lane i retires if lane i−1 retires and entry (head+i) is valid and done.
- On retire, the entry's valid bit is cleared and head advances by the number of retiring lanes.
- Two retiring lanes with the same `isa_rd`: the retired RAT applies the higher lane last, which is the correct program order. The ROB takes no special action.
- Priority: `rst` > `flush` > normal.
  - `flush` clears all valid/done bits and sets head = tail = 0.
  - During a `flush` cycle, retire outputs and CDB and dispatch inputs are ignored.

## Timing
- Reset and post-flush state:
  - Pointers 0, all entries invalid.
  - `rob_empty`=1, `rob_full`=0, `dispatch_ready`=1.
  - `retire_we`, `retire_valid`, `free_valid` = 0; rd/phys outputs 0.
- Dispatch at edge N: the entry is valid from cycle N+1.
- CDB at edge M: `retire_*` asserts in cycle M+1 if the entry is oldest. Minimum completion-to-retire latency is 1 cycle.
- `dispatch_ready` is computed from the current count only. Same-cycle retirement is not credited, which is conservative.
- Dispatch and retire in the same cycle: count updates by (dispatched − retired); both pointers wrap independently.
- Dispatch into the last SS free slots makes `rob_full`=1 in the next cycle.
- A CDB targeting an entry being dispatched in the same cycle is illegal. The bench asserts it never occurs.

## Structure
- Shared package `rv32i_types` gains:
  - `rob_entry_t`
  - `ROB_DEPTH`
  - `ROB_IDX_W`
  - `PHYS_IDX_W`, shared with the RAT and free list.
- Single module; no sub-module. Retire selection is an SS-lane prefix chain inside the block.

## Test plan
- Reset, then idle: `rob_empty`=1, `dispatch_ready`=1, `retire_we`=0.
- Dispatch lanes {x5→p33 (old p5), x6→p34 (old p6)}, then CDB for idx 1 only:
  - No retire.
  - After CDB idx 0: both lanes retire in one cycle, `retire_isa_rd`={5,6}, `free_phys_rd`={5,6}.
- Oldest entry not done, younger done: no retire until the oldest completes. Then both retire the cycle after.
- Fill to 16 entries with DEPTH=16:
  - `rob_full`=1 and `dispatch_ready`=0.
  - Retire 2: `dispatch_ready`=1 the next cycle.
  - Run 40 dispatch/retire rounds to exercise pointer wrap; indices continue 15→0.
- Entry with `isa_rd`=0 retires:
  - `retire_valid`=1, `retire_isa_rd`=0, `free_valid`=0.
- `flush` with 5 entries pending and a simultaneous CDB:
  - Next cycle `rob_empty`=1, pointers 0.
  - The CDB has no effect.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared core types: ROB entry layout and index widths used by the ROB, RAT and free list.
package rv32i_types;
  localparam int ROB_DEPTH  = 16;
  localparam int ROB_IDX_W  = $clog2(ROB_DEPTH);
  localparam int PHYS_IDX_W = 6;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic [4:0]            isa_rd;
    logic [PHYS_IDX_W-1:0] phys_rd;
    logic [PHYS_IDX_W-1:0] old_phys_rd;
  } rob_entry_t;
endpackage

// File: rtl/reorder_buffer.sv
// SS-wide in-order reorder buffer: prefix dispatch, CDB completion, in-order retire of up to SS entries.
module reorder_buffer #(
  parameter int SS        = 2,
  parameter int ROB_DEPTH = rv32i_types::ROB_DEPTH,
  parameter int PHYS_W    = rv32i_types::PHYS_IDX_W,
  parameter int ROB_W     = $clog2(ROB_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [SS-1:0]                dispatch_valid,
  input  logic [SS-1:0][4:0]           dispatch_isa_rd,
  input  logic [SS-1:0][PHYS_W-1:0]    dispatch_phys_rd,
  input  logic [SS-1:0][PHYS_W-1:0]    dispatch_old_phys_rd,
  output logic                         dispatch_ready,
  output logic [SS-1:0][ROB_W-1:0]     dispatch_rob_idx,
  input  logic [SS-1:0]                cdb_valid,
  input  logic [SS-1:0][ROB_W-1:0]     cdb_rob_idx,
  output logic                         retire_we,
  output logic [SS-1:0]                retire_valid,
  output logic [SS-1:0][4:0]           retire_isa_rd,
  output logic [SS-1:0][PHYS_W-1:0]    retire_phys_rd,
  output logic [SS-1:0]                free_valid,
  output logic [SS-1:0][PHYS_W-1:0]    free_phys_rd,
  output logic                         rob_empty,
  output logic                         rob_full
);
  import rv32i_types::*;

  localparam int PTR_W = ROB_W + 1;
  localparam int CNT_W = $clog2(SS + 1);
  localparam logic [PTR_W-1:0] READY_MAX = PTR_W'(ROB_DEPTH - SS);

  rob_entry_t                entries [ROB_DEPTH];
  logic [PTR_W-1:0]          head_ptr, tail_ptr, count;
  logic [SS-1:0][ROB_W-1:0]  ret_idx;
  logic [CNT_W-1:0]          num_ret, num_disp;
  logic                      disp_fire;

  assign count          = tail_ptr - head_ptr;
  assign rob_empty      = (head_ptr == tail_ptr);
  assign rob_full       = (head_ptr[ROB_W-1:0] == tail_ptr[ROB_W-1:0]) &&
                          (head_ptr[ROB_W] != tail_ptr[ROB_W]);
  // Conservative: same-cycle retirement does not free room for dispatch.
  assign dispatch_ready = (count <= READY_MAX);
  assign disp_fire      = dispatch_ready && (|dispatch_valid);
  assign retire_we      = |retire_valid;

  always_comb begin
    num_disp = '0;
    for (int i = 0; i < SS; i++) begin
      dispatch_rob_idx[i] = tail_ptr[ROB_W-1:0] + ROB_W'(i);
      num_disp            = num_disp + CNT_W'(dispatch_valid[i]);
    end
  end

  // Prefix chain: a lane retires only if every older lane retires too.
  always_comb begin
    logic chain;
    chain          = 1'b1;
    num_ret        = '0;
    retire_valid   = '0;
    retire_isa_rd  = '0;
    retire_phys_rd = '0;
    free_valid     = '0;
    free_phys_rd   = '0;
    for (int i = 0; i < SS; i++) begin
      ret_idx[i] = head_ptr[ROB_W-1:0] + ROB_W'(i);
      chain      = chain && entries[ret_idx[i]].valid && entries[ret_idx[i]].done;
      if (chain) begin
        retire_valid[i]   = 1'b1;
        retire_isa_rd[i]  = entries[ret_idx[i]].isa_rd;
        retire_phys_rd[i] = entries[ret_idx[i]].phys_rd;
        num_ret           = num_ret + CNT_W'(1);
        if (entries[ret_idx[i]].isa_rd != 5'd0) begin
          free_valid[i]   = 1'b1;
          free_phys_rd[i] = entries[ret_idx[i]].old_phys_rd;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      for (int j = 0; j < ROB_DEPTH; j++) entries[j] <= '0;
    end else begin
      for (int i = 0; i < SS; i++)
        if (cdb_valid[i] && entries[cdb_rob_idx[i]].valid)
          entries[cdb_rob_idx[i]].done <= 1'b1;
      for (int i = 0; i < SS; i++)
        if (retire_valid[i]) begin
          entries[ret_idx[i]].valid <= 1'b0;
          entries[ret_idx[i]].done  <= 1'b0;
        end
      // Dispatch slots are free when ready, so they never alias retiring entries.
      if (disp_fire) begin
        for (int i = 0; i < SS; i++)
          if (dispatch_valid[i])
            entries[dispatch_rob_idx[i]] <= '{valid: 1'b1, done: 1'b0,
                                              isa_rd: dispatch_isa_rd[i],
                                              phys_rd: dispatch_phys_rd[i],
                                              old_phys_rd: dispatch_old_phys_rd[i]};
        tail_ptr <= tail_ptr + PTR_W'(num_disp);
      end
      head_ptr <= head_ptr + PTR_W'(num_ret);
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected retire records queued at dispatch, popped by a retire monitor.
module tb_reorder_buffer;
  logic                 clk, rst, flush;
  logic [1:0]           dispatch_valid;
  logic [1:0][4:0]      dispatch_isa_rd;
  logic [1:0][5:0]      dispatch_phys_rd, dispatch_old_phys_rd;
  logic                 dispatch_ready;
  logic [1:0][3:0]      dispatch_rob_idx;
  logic [1:0]           cdb_valid;
  logic [1:0][3:0]      cdb_rob_idx;
  logic                 retire_we;
  logic [1:0]           retire_valid, free_valid;
  logic [1:0][4:0]      retire_isa_rd;
  logic [1:0][5:0]      retire_phys_rd, free_phys_rd;
  logic                 rob_empty, rob_full;

  reorder_buffer #(.SS(2), .ROB_DEPTH(16), .PHYS_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_isa_rd(dispatch_isa_rd),
    .dispatch_phys_rd(dispatch_phys_rd), .dispatch_old_phys_rd(dispatch_old_phys_rd),
    .dispatch_ready(dispatch_ready), .dispatch_rob_idx(dispatch_rob_idx),
    .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx),
    .retire_we(retire_we), .retire_valid(retire_valid), .retire_isa_rd(retire_isa_rd),
    .retire_phys_rd(retire_phys_rd), .free_valid(free_valid), .free_phys_rd(free_phys_rd),
    .rob_empty(rob_empty), .rob_full(rob_full)
  );

  typedef struct {
    logic [4:0] isa;
    logic [5:0] phys;
    logic [5:0] old;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] pend[$];
  int         tb_tail;
  int         checks, errs;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; the model tail, pending list and scoreboard follow the dispatch.
  task automatic cyc(input int nd,
                     input logic [4:0] r0, input logic [5:0] p0, input logic [5:0] o0,
                     input logic [4:0] r1, input logic [5:0] p1, input logic [5:0] o1,
                     input logic [1:0] cv, input logic [3:0] c0, input logic [3:0] c1,
                     input logic fl);
    dispatch_valid       = (nd == 2) ? 2'b11 : (nd == 1) ? 2'b01 : 2'b00;
    dispatch_isa_rd      = {r1, r0};
    dispatch_phys_rd     = {p1, p0};
    dispatch_old_phys_rd = {o1, o0};
    cdb_valid            = cv;
    cdb_rob_idx          = {c1, c0};
    flush                = fl;
    if (fl) begin
      sb.delete();
      pend.delete();
      tb_tail = 0;
    end else begin
      if (nd >= 1) begin
        sb.push_back('{r0, p0, o0});
        pend.push_back(4'(tb_tail));
        tb_tail = (tb_tail + 1) % 32;
      end
      if (nd == 2) begin
        sb.push_back('{r1, p1, o1});
        pend.push_back(4'(tb_tail));
        tb_tail = (tb_tail + 1) % 32;
      end
    end
    tick();
    dispatch_valid = '0;
    cdb_valid      = '0;
    flush          = 1'b0;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1'b0);
  endtask

  // Retire monitor: every retiring lane must match the oldest expected record.
  always @(negedge clk) begin
    if (!rst && !flush) begin
      checks++;
      if (retire_we !== (|retire_valid) || retire_valid === 2'b10) begin
        errs++;
        $display("FAIL retire_we_prefix: we=%b valid=%b", retire_we, retire_valid);
      end
      for (int i = 0; i < 2; i++) begin
        if (retire_valid[i] === 1'b1) begin
          if (sb.size() == 0) begin
            errs++;
            $display("FAIL unexpected_retire lane %0d: isa_rd=%0d, none expected", i, retire_isa_rd[i]);
          end else begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (retire_isa_rd[i] !== e.isa || retire_phys_rd[i] !== e.phys ||
                free_valid[i] !== (e.isa != 0) ||
                (e.isa != 0 && free_phys_rd[i] !== e.old)) begin
              errs++;
              $display("FAIL retire_data lane %0d: got isa=%0d phys=%0d free=%b old=%0d, want isa=%0d phys=%0d free=%b old=%0d",
                       i, retire_isa_rd[i], retire_phys_rd[i], free_valid[i], free_phys_rd[i],
                       e.isa, e.phys, (e.isa != 0), e.old);
            end
          end
        end else begin
          checks++;
          if (retire_isa_rd[i] !== 5'd0 || retire_phys_rd[i] !== 6'd0 || free_valid[i] !== 1'b0) begin
            errs++;
            $display("FAIL idle_lane_zero lane %0d: isa=%0d phys=%0d free=%b, want 0/0/0",
                     i, retire_isa_rd[i], retire_phys_rd[i], free_valid[i]);
          end
        end
      end
    end
  end

  // Protocol guard: a CDB must never target an entry being dispatched in the same cycle.
  always @(posedge clk) begin
    if (!rst && !flush && dispatch_ready)
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          if (cdb_valid[i] && dispatch_valid[j] && cdb_rob_idx[i] == dispatch_rob_idx[j]) begin
            errs++;
            $display("FAIL cdb_dispatch_collision: cdb lane %0d idx %0d hits dispatch lane %0d", i, cdb_rob_idx[i], j);
          end
  end

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    dispatch_valid = '0; dispatch_isa_rd = '0; dispatch_phys_rd = '0; dispatch_old_phys_rd = '0;
    cdb_valid = '0; cdb_rob_idx = '0;
    tb_tail = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (rob_empty !== 1'b1 || rob_full !== 1'b0 || dispatch_ready !== 1'b1 || retire_we !== 1'b0 ||
        retire_valid !== 2'b00 || free_valid !== 2'b00 || dispatch_rob_idx !== {4'd1, 4'd0}) begin
      errs++;
      $display("FAIL reset_state: empty=%b full=%b ready=%b we=%b rv=%b fv=%b idx=%h, want 1 0 1 0 00 00 10",
               rob_empty, rob_full, dispatch_ready, retire_we, retire_valid, free_valid, dispatch_rob_idx);
    end
  endtask

  task automatic test_basic();
    checks++;
    if (dispatch_rob_idx !== {4'd1, 4'd0}) begin
      errs++; $display("FAIL basic_idx: got %h want 10", dispatch_rob_idx);
    end
    cyc(2, 5'd5, 6'd33, 6'd5, 5'd6, 6'd34, 6'd6, 2'b00, 0, 0, 1'b0);
    checks++;
    if (rob_empty !== 1'b0) begin errs++; $display("FAIL basic_not_empty: got %b want 0", rob_empty); end
    cyc(0, 0, 0, 0, 0, 0, 0, 2'b01, 4'd1, 0, 1'b0);
    checks++;
    if (retire_we !== 1'b0) begin errs++; $display("FAIL basic_young_done_no_retire: got %b want 0", retire_we); end
    cyc(0, 0, 0, 0, 0, 0, 0, 2'b01, 4'd0, 0, 1'b0);
    checks++;
    if (retire_valid !== 2'b11 || retire_isa_rd !== {5'd6, 5'd5} || free_phys_rd !== {6'd6, 6'd5}) begin
      errs++;
      $display("FAIL basic_dual_retire: rv=%b isa=%h free=%h, want 11 isa{6,5} free{6,5}",
               retire_valid, retire_isa_rd, free_phys_rd);
    end
    void'(pend.pop_front()); void'(pend.pop_front());
    idle();
    checks++;
    if (rob_empty !== 1'b1) begin errs++; $display("FAIL basic_drained: got %b want 1", rob_empty); end
  endtask

  task automatic test_oldest_blocks();
    cyc(2, 5'd7, 6'd35, 6'd7, 5'd8, 6'd36, 6'd8, 2'b00, 0, 0, 1'b0);
    cyc(2, 5'd9, 6'd37, 6'd9, 5'd10, 6'd38, 6'd10, 2'b01, 4'd3, 0, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 0, 2'b11, 4'd4, 4'd5, 1'b0);
    checks++;
    if (retire_we !== 1'b0) begin errs++; $display("FAIL oldest_blocks_a: we=%b want 0", retire_we); end
    idle();
    checks++;
    if (retire_we !== 1'b0) begin errs++; $display("FAIL oldest_blocks_b: we=%b want 0", retire_we); end
    cyc(0, 0, 0, 0, 0, 0, 0, 2'b01, 4'd2, 0, 1'b0);
    checks++;
    if (retire_valid !== 2'b11) begin errs++; $display("FAIL oldest_release_1: rv=%b want 11", retire_valid); end
    idle();
    checks++;
    if (retire_valid !== 2'b11) begin errs++; $display("FAIL oldest_release_2: rv=%b want 11", retire_valid); end
    idle();
    checks++;
    if (rob_empty !== 1'b1) begin errs++; $display("FAIL oldest_drained: got %b want 1", rob_empty); end
    pend.delete();
  endtask

  task automatic test_full_and_wrap();
    logic [3:0] c0, c1;
    int n;
    for (int k = 0; k < 8; k++) begin
      cyc(2, 5'(k + 1), 6'(k + 40), 6'(k + 1), 5'(k + 11), 6'(k + 50), 6'(k + 11), 2'b00, 0, 0, 1'b0);
      if (k == 6) begin
        checks++;
        if (dispatch_ready !== 1'b1 || rob_full !== 1'b0) begin
          errs++; $display("FAIL count14_ready: ready=%b full=%b want 1 0", dispatch_ready, rob_full);
        end
      end
    end
    checks++;
    if (rob_full !== 1'b1 || dispatch_ready !== 1'b0 || dispatch_rob_idx[0] !== 4'(tb_tail)) begin
      errs++; $display("FAIL full_state: full=%b ready=%b idx=%0d want 1 0 %0d",
                       rob_full, dispatch_ready, dispatch_rob_idx[0], tb_tail % 16);
    end
    // Dispatch while not ready must be dropped.
    dispatch_valid = 2'b11; dispatch_isa_rd = {5'd31, 5'd30};
    tick();
    dispatch_valid = '0;
    checks++;
    if (rob_full !== 1'b1 || dispatch_rob_idx[0] !== 4'(tb_tail)) begin
      errs++; $display("FAIL not_ready_ignored: full=%b idx=%0d want 1 %0d", rob_full, dispatch_rob_idx[0], tb_tail % 16);
    end
    c0 = pend.pop_front(); c1 = pend.pop_front();
    cyc(0, 0, 0, 0, 0, 0, 0, 2'b11, c0, c1, 1'b0);
    checks++;
    if (retire_valid !== 2'b11 || dispatch_ready !== 1'b0) begin
      errs++; $display("FAIL full_retire_no_credit: rv=%b ready=%b want 11 0", retire_valid, dispatch_ready);
    end
    idle();
    checks++;
    if (dispatch_ready !== 1'b1 || rob_full !== 1'b0) begin
      errs++; $display("FAIL ready_after_retire: ready=%b full=%b want 1 0", dispatch_ready, rob_full);
    end
    for (int r = 0; r < 40; r++) begin
      checks++;
      if (dispatch_rob_idx !== {4'(tb_tail + 1), 4'(tb_tail)}) begin
        errs++; $display("FAIL wrap_idx round %0d: got %h want %0d/%0d", r, dispatch_rob_idx,
                         (tb_tail + 1) % 16, tb_tail % 16);
      end
      c0 = pend.pop_front(); c1 = pend.pop_front();
      cyc(2, 5'((r % 30) + 1), 6'(r + 1), 6'(r + 20), 5'(((r + 7) % 30) + 1), 6'(r + 2), 6'(r + 21),
          2'b11, c0, c1, 1'b0);
      checks++;
      if (retire_valid !== 2'b11) begin errs++; $display("FAIL wrap_retire round %0d: rv=%b want 11", r, retire_valid); end
      idle();
    end
    while (pend.size() >= 2) begin
      c0 = pend.pop_front(); c1 = pend.pop_front();
      cyc(0, 0, 0, 0, 0, 0, 0, 2'b11, c0, c1, 1'b0);
    end
    n = 0;
    while (rob_empty !== 1'b1 && n < 20) begin idle(); n++; end
    checks++;
    if (rob_empty !== 1'b1) begin errs++; $display("FAIL drain_timeout: empty=%b after %0d cycles", rob_empty, n); end
  endtask

  task automatic test_rd_zero();
    logic [3:0] c0, c1;
    cyc(2, 5'd0, 6'd40, 6'd7, 5'd9, 6'd41, 6'd9, 2'b00, 0, 0, 1'b0);
    c0 = pend.pop_front(); c1 = pend.pop_front();
    cyc(0, 0, 0, 0, 0, 0, 0, 2'b11, c0, c1, 1'b0);
    checks++;
    if (retire_valid !== 2'b11 || retire_isa_rd[0] !== 5'd0 || retire_phys_rd[0] !== 6'd40 ||
        free_valid !== 2'b10) begin
      errs++; $display("FAIL rd_zero: rv=%b isa0=%0d phys0=%0d fv=%b want 11 0 40 10",
                       retire_valid, retire_isa_rd[0], retire_phys_rd[0], free_valid);
    end
    idle();
  endtask

  task automatic test_flush();
    cyc(2, 5'd1, 6'd10, 6'd1, 5'd2, 6'd11, 6'd2, 2'b00, 0, 0, 1'b0);
    cyc(2, 5'd3, 6'd12, 6'd3, 5'd4, 6'd13, 6'd4, 2'b00, 0, 0, 1'b0);
    cyc(1, 5'd5, 6'd14, 6'd5, 5'd0, 6'd0, 6'd0, 2'b01, pend[1], 0, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 0, 2'b01, pend[2], 0, 1'b1);
    checks++;
    if (rob_empty !== 1'b1 || rob_full !== 1'b0 || dispatch_ready !== 1'b1 || retire_we !== 1'b0 ||
        dispatch_rob_idx !== {4'd1, 4'd0}) begin
      errs++; $display("FAIL flush_state: empty=%b full=%b ready=%b we=%b idx=%h want 1 0 1 0 10",
                       rob_empty, rob_full, dispatch_ready, retire_we, dispatch_rob_idx);
    end
    for (int k = 0; k < 3; k++) begin
      idle();
      checks++;
      if (retire_we !== 1'b0 || rob_empty !== 1'b1) begin
        errs++; $display("FAIL flush_quiet %0d: we=%b empty=%b want 0 1", k, retire_we, rob_empty);
      end
    end
    // Stale done bits must be gone: only the completed idx 0 may retire.
    cyc(2, 5'd3, 6'd50, 6'd3, 5'd4, 6'd51, 6'd4, 2'b00, 0, 0, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 0, 2'b01, 4'd0, 0, 1'b0);
    checks++;
    if (retire_valid !== 2'b01) begin errs++; $display("FAIL flush_no_stale_done: rv=%b want 01", retire_valid); end
    cyc(0, 0, 0, 0, 0, 0, 0, 2'b01, 4'd1, 0, 1'b0);
    checks++;
    if (retire_valid !== 2'b01) begin errs++; $display("FAIL flush_second: rv=%b want 01", retire_valid); end
    idle();
    checks++;
    if (rob_empty !== 1'b1) begin errs++; $display("FAIL flush_final_empty: got %b want 1", rob_empty); end
  endtask

  initial begin
    checks = 0; errs = 0;
    test_reset();
    test_basic();
    test_oldest_blocks();
    test_full_and_wrap();
    test_rd_zero();
    test_flush();
    idle();
    checks++;
    if (sb.size() != 0) begin errs++; $display("FAIL scoreboard_leftover: %0d records never retired", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
